// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_pkg
// Description : Shared mode encodings and width helpers for the stream mux.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel-index width, never narrower than one bit
    function automatic int sel_width(input int n_ch);
        return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Searches for the first requester
//               starting one past the last winner, wrapping N_CH-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [N_CH-1:0]  gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx
);

    logic w_found;

    // Walk priority positions last+1, last+2, ... and take the first requester
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        w_found    = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!w_found && req[i] && (((int'(last) + k) % N_CH) == i)) begin
                    w_found       = 1'b1;
                    gnt_onehot[i] = 1'b1;
                    gnt_idx       = SEL_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel valid/ready stream multiplexer with fixed-select or
//               round-robin arbitration and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = sel_width(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic              w_load_en;
    logic              w_accept;
    logic [N_CH-1:0]   w_fixed_gnt;
    logic [N_CH-1:0]   w_rr_gnt;
    logic [N_CH-1:0]   w_gnt;
    logic [SEL_W-1:0]  w_rr_idx;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [DATA_W-1:0] w_gnt_data;

    logic [SEL_W-1:0]  r_last_q,      w_last_d;
    logic [DATA_W-1:0] r_out_data_q,  w_out_data_d;
    logic [SEL_W-1:0]  r_out_ch_q,    w_out_ch_d;
    logic              r_out_valid_q, w_out_valid_d;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req        (in_valid),
        .last       (r_last_q),
        .gnt_onehot (w_rr_gnt),
        .gnt_idx    (w_rr_idx)
    );

    // Fixed-mode grant: sel values beyond the last channel never match
    always_comb begin
        w_fixed_gnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_fixed_gnt[i] = in_valid[i] && (sel == SEL_W'(i));
        end
    end

    // Mode select and input handshake; nothing is offered while in reset
    always_comb begin
        w_load_en = !r_out_valid_q || out_ready;
        if (mode == MODE_RR) begin
            w_gnt     = w_rr_gnt;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_gnt     = w_fixed_gnt;
            w_gnt_idx = sel;
        end
        in_ready = (w_load_en && rst_n) ? w_gnt : '0;
        w_accept = |in_ready;
    end

    // Route the granted channel's word to the output register
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) begin
                w_gnt_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: capture on accept, drop valid when loadable with no grant
    always_comb begin
        w_last_d      = r_last_q;
        w_out_data_d  = r_out_data_q;
        w_out_ch_d    = r_out_ch_q;
        w_out_valid_d = r_out_valid_q;
        if (w_accept) begin
            w_last_d     = w_gnt_idx;
            w_out_data_d = w_gnt_data;
            w_out_ch_d   = w_gnt_idx;
        end
        if (w_load_en) begin
            w_out_valid_d = w_accept;
        end
    end

    // State registers; reset makes channel 0 the first round-robin winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_q      <= SEL_W'(N_CH - 1);
            r_out_data_q  <= '0;
            r_out_ch_q    <= '0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_last_q      <= w_last_d;
            r_out_data_q  <= w_out_data_d;
            r_out_ch_q    <= w_out_ch_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_ch    = r_out_ch_q;
    assign out_valid = r_out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Scoreboard bench for stream_mux_rr. Two instances (4x8 and
//               3x16) share stimulus; a transaction-level model predicts
//               grants and output words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        out_ready = 1'b0;
    logic [3:0]  tb_valid = 4'd0;
    logic [15:0] ch_data [4];
    logic [15:0] next_data [4];

    logic [31:0] in_data4;
    logic [47:0] in_data3;
    logic [3:0]  rdy4;
    logic [2:0]  rdy3;
    logic [7:0]  od4;
    logic [15:0] od3;
    logic [1:0]  oc4, oc3;
    logic        ov4, ov3;

    always #5 clk = ~clk;

    assign in_data4 = {ch_data[3][7:0], ch_data[2][7:0], ch_data[1][7:0], ch_data[0][7:0]};
    assign in_data3 = {ch_data[2], ch_data[1], ch_data[0]};

    stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(tb_valid),
        .in_ready(rdy4), .mode(mode), .sel(sel), .out_data(od4),
        .out_ch(oc4), .out_valid(ov4), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .DATA_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(tb_valid[2:0]),
        .in_ready(rdy3), .mode(mode), .sel(sel), .out_data(od3),
        .out_ch(oc3), .out_valid(ov3), .out_ready(out_ready)
    );

    typedef struct {
        int          ch;
        logic [15:0] data;
    } item_t;

    item_t      sb0[$], sb1[$];
    int         obs0[$], obs1[$];
    int         m_last [2];
    bit         m_ov_cur [2];
    bit         m_ov_next [2];
    logic [3:0] exp_ready [2];
    bit         mon_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Spec-level model: one call per clock cycle after inputs are applied
    task automatic model_cycle();
        for (int d = 0; d < 2; d++) begin
            int n;
            int g;
            bit load;
            n = (d == 0) ? 4 : 3;
            g = -1;
            m_ov_cur[d] = m_ov_next[d];
            load = !m_ov_cur[d] || out_ready;
            if (mode == 1'b0) begin
                if (int'(sel) < n && tb_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 1; k <= n; k++) begin
                    int c;
                    c = (m_last[d] + k) % n;
                    if (g < 0 && tb_valid[c]) g = c;
                end
            end
            exp_ready[d] = 4'd0;
            if (load) begin
                if (g >= 0) begin
                    item_t it;
                    exp_ready[d][g] = 1'b1;
                    m_last[d] = g;
                    it.ch = g;
                    it.data = (d == 0) ? {8'h00, ch_data[g][7:0]} : ch_data[g];
                    if (d == 0) sb0.push_back(it); else sb1.push_back(it);
                end
                m_ov_next[d] = (g >= 0);
            end
        end
    endtask

    task automatic step(input bit md, input logic [1:0] s, input logic [3:0] v, input bit ordy);
        @(posedge clk);
        #1;
        mode = md;
        sel = s;
        tb_valid = v;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) ch_data[i] = next_data[i];
        model_cycle();
    endtask

    task automatic clear_obs();
        obs0.delete();
        obs1.delete();
    endtask

    // Assert reset between edges, check outputs clear at once, then release
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid4", ov4, 0);
        check("rst_out_ch4", oc4, 0);
        check("rst_out_data4", od4, 0);
        check("rst_in_ready4", rdy4, 0);
        check("rst_out_valid3", ov3, 0);
        check("rst_out_ch3", oc3, 0);
        check("rst_out_data3", od3, 0);
        check("rst_in_ready3", rdy3, 0);
        tb_valid = 4'd0;
        m_last[0] = 3;
        m_last[1] = 2;
        for (int d = 0; d < 2; d++) begin
            m_ov_cur[d] = 1'b0;
            m_ov_next[d] = 1'b0;
            exp_ready[d] = 4'd0;
        end
        sb0.delete();
        sb1.delete();
        clear_obs();
        mon_en = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic pop_cmp(input int d, input int ch, input logic [15:0] data);
        item_t it;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output%0d: got ch %0d data %0h expected none", d, ch, data);
        end else begin
            if (d == 0) it = sb0.pop_front(); else it = sb1.pop_front();
            check($sformatf("out_ch_dut%0d", d), ch, it.ch);
            check($sformatf("out_data_dut%0d", d), data, it.data);
            if (d == 0) obs0.push_back(ch); else obs1.push_back(ch);
        end
    endtask

    // Monitor: mid-cycle compare of ready, valid and output handshakes
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready4", rdy4, exp_ready[0]);
            check("in_ready3", rdy3, exp_ready[1][2:0]);
            check("out_valid4", ov4, m_ov_cur[0]);
            check("out_valid3", ov3, m_ov_cur[1]);
            if (ov4 && out_ready) pop_cmp(0, int'(oc4), {8'h00, od4});
            if (ov3 && out_ready) pop_cmp(1, int'(oc3), od3);
        end
    end

    task automatic check_seq(input int d, input int e[5], input int cnt, input string nm);
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = -1;
            if (d == 0) begin
                if (i < obs0.size()) a = obs0[i];
            end else begin
                if (i < obs1.size()) a = obs1[i];
            end
            check($sformatf("%s[%0d]", nm, i), a, e[i]);
        end
    endtask

    initial begin
        int e[5];
        for (int i = 0; i < 4; i++) begin
            ch_data[i] = 16'd0;
            next_data[i] = 16'd0;
        end
        do_reset();

        // Round-robin, all channels valid, data 0x10+i
        for (int i = 0; i < 4; i++) next_data[i] = 16'h0010 + 16'(i);
        repeat (6) step(1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 2'd0, 4'b0000, 1'b1);
        e = '{0, 1, 2, 3, 0};
        check_seq(0, e, 5, "rr_seq4");
        e = '{0, 1, 2, 0, 1};
        check_seq(1, e, 5, "rr_seq3");

        // Fixed mode, sel=2, channels 1 and 2 valid
        clear_obs();
        for (int i = 0; i < 4; i++) next_data[i] = 16'($urandom);
        repeat (5) step(1'b0, 2'd2, 4'b0110, 1'b1);
        repeat (2) step(1'b0, 2'd2, 4'b0000, 1'b1);
        e = '{2, 2, 2, 2, 2};
        check_seq(0, e, 5, "fixed_seq4");
        check_seq(1, e, 5, "fixed_seq3");

        // Backpressure: hold 0xA5 for three cycles, last must not move
        do_reset();
        next_data[0] = 16'h00A5;
        step(1'b0, 2'd0, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b0);
            #3;
            check("bp_hold_data4", od4, 8'hA5);
            check("bp_hold_ch4", oc4, 0);
            check("bp_hold_data3", od3, 16'h00A5);
        end
        repeat (3) step(1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 2'd0, 4'b0000, 1'b1);
        e = '{0, 1, 2, 3, 0};
        check_seq(0, e, 4, "bp_seq4");
        e = '{0, 1, 2, 0, 0};
        check_seq(1, e, 3, "bp_seq3");

        // Sparse round-robin: only ch3 and ch0 valid, starting from last=3
        do_reset();
        repeat (3) step(1'b1, 2'd0, 4'b1001, 1'b1);
        repeat (2) step(1'b1, 2'd0, 4'b0000, 1'b1);
        e = '{0, 3, 0, 0, 0};
        check_seq(0, e, 3, "sparse_seq4");
        e = '{0, 0, 0, 0, 0};
        check_seq(1, e, 3, "sparse_seq3");

        // sel beyond the 3-channel instance: no grant there
        repeat (2) step(1'b0, 2'd3, 4'b1111, 1'b1);
        #3;
        check("sel_oob_valid3", ov3, 0);
        check("sel_oob_ready3", rdy3, 0);

        // Reset while a word is held in the output register
        step(1'b1, 2'd0, 4'b1111, 1'b0);
        step(1'b1, 2'd0, 4'b1111, 1'b0);
        #3;
        check("pre_reset_valid4", ov4, 1);
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) next_data[i] = 16'($urandom);
            step(1'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(3, 0) != 0));
        end
        repeat (3) step(1'b0, 2'd0, 4'b0000, 1'b1);
        check("sb_empty4", sb0.size(), 0);
        check("sb_empty3", sb1.size(), 0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the data width per channel (legal range 1..64).
REQ-003 The block SHALL have derived constant SEL_W = max(1, clog2(N_CH)).
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst_n: input, 1 bit, reset; asynchronous and active-low.
REQ-006 Port in_data: input, N_CH*DATA_W bits; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port in_valid: input, N_CH bits, per-channel valid.
REQ-008 Port in_ready: output, N_CH bits, per-channel ready.
REQ-009 Port mode: input, 1 bit; 0 = fixed select, 1 = round-robin.
REQ-010 Port sel: input, SEL_W bits, the channel index used in fixed mode.
REQ-011 Port out_data: output, DATA_W bits, registered data.
REQ-012 Port out_ch: output, SEL_W bits, registered source-channel index of out_data.
REQ-013 Port out_valid: output, 1 bit, registered valid.
REQ-014 Port out_ready: input, 1 bit, downstream ready.

Function
REQ-015 A transfer on input i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; the output transfers when out_valid and out_ready are both 1.
REQ-016 The output stage SHALL be one register; it may load when out_valid=0 or out_ready=1 (load_en).
REQ-017 At most one in_ready bit SHALL be 1 in any cycle, and only when load_en=1.
REQ-018 In fixed mode, grant SHALL go to channel sel if in_valid[sel]=1; otherwise no grant.
REQ-019 In fixed mode with sel >= N_CH, there SHALL be no grant and no transfer.
REQ-020 In round-robin mode, grant SHALL go to the first channel with valid=1, searching from (last+1) mod N_CH upward with wrap-around N_CH-1 -> 0.
REQ-021 The last pointer SHALL update to the granted index only on an accepted input transfer, in either mode.
REQ-022 in_ready SHALL depend combinationally on in_valid, mode, sel, last, out_valid and out_ready, and SHALL NOT depend on in_data.
REQ-023 On an accepted transfer, out_data, out_ch and out_valid=1 SHALL be registered on the next clock edge; latency is 1 cycle.
REQ-024 If load_en=1 and there is no grant, out_valid SHALL become 0 on the next edge.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable.
REQ-026 With out_ready held at 1, sustained throughput SHALL be one word per cycle with no bubbles.
REQ-027 A change of mode or sel SHALL take effect on the same cycle's grant; last is not cleared by a mode change.
REQ-028 Simultaneous output drain and input accept SHALL both complete in the same cycle.

Reset
REQ-029 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_ch=0, and last=N_CH-1, so channel 0 has first round-robin priority.
REQ-030 While rst_n=0, all in_ready bits SHALL be 0.
REQ-031 A word held in the output register SHALL be discarded on reset, with no partial transfer.

Structure
REQ-032 A shared package SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and a clog2 helper function.
REQ-033 The block SHALL contain one sub-module, rr_arbiter, parametrised by N_CH, with inputs req[N_CH] and last[SEL_W] and outputs gnt_onehot and gnt_idx.

Verification
REQ-034 Reset test: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_ch=0 and in_ready=0 immediately, without waiting for a clock edge.
REQ-035 Round-robin test: N_CH=4, DATA_W=8, mode=1, all valid, out_ready=1, in_data ch i = 0x10+i -> out_ch sequence 0,1,2,3,0 and out_data 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
REQ-036 Fixed-mode test: mode=0, sel=2, only ch1 and ch2 valid -> only in_ready[2]=1, and out_ch=2 every cycle.
REQ-037 Backpressure test: out_ready=0 for 3 cycles with out_valid=1 and out_data=0xA5 -> out_data stays 0xA5, in_ready=0 throughout, and last is unchanged.
REQ-038 Sparse round-robin test: only ch3 and ch0 valid, last=3 -> ch0 is granted, then ch3, then ch0 (wrap-around).
REQ-039 Parameter test: N_CH=3, mode=0, sel=3 -> no grant and out_valid=0; repeat the round-robin test with N_CH=3 and DATA_W=16.
